// File: rtl/ws2811_frame_scheduler.sv
// WS2811 frame scheduler: steps LED indices, samples the colour pipeline, hands pixels to the serializer.
// Optional macro SCHED_PENDING_TICK_EN queues one frame_tick received while busy.
module ws2811_frame_scheduler #(
    parameter int unsigned NUM_LEDS     = 50,
    parameter int unsigned PIXEL_CYCLES = 8,
    parameter int unsigned LATCH_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    output logic [7:0]  ledindex,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix_data,
    output logic        latch,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int unsigned CntMax = (PIXEL_CYCLES > LATCH_CYCLES) ? PIXEL_CYCLES : LATCH_CYCLES;
    // Counter only ever holds reload values of CntMax-1 or less.
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] PixReload   = CntW'(PIXEL_CYCLES - 1);
    localparam logic [CntW-1:0] LatchReload = CntW'(LATCH_CYCLES - 1);
    localparam logic [7:0]      LastLed     = 8'(NUM_LEDS - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StPresent, StLatch} state_t;

    state_t          state;
    logic [CntW-1:0] cnt;
`ifdef SCHED_PENDING_TICK_EN
    logic            pending;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= '0;
            ledindex    <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            latch       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
`ifdef SCHED_PENDING_TICK_EN
            pending     <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef SCHED_PENDING_TICK_EN
            if (frame_tick && (state != StIdle)) begin
                pending <= 1'b1;
            end
`endif
            unique case (state)
                StIdle: begin
                    if (frame_tick) begin
                        ledindex <= '0;
                        cnt      <= PixReload;
                        busy     <= 1'b1;
                        state    <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt == '0) begin
                        pix_data  <= {red, green, blue};
                        pix_valid <= 1'b1;
                        state     <= StPresent;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StPresent: begin
                    if (pix_valid && pix_ready) begin
                        pix_valid <= 1'b0;
                        if (ledindex == LastLed) begin
                            cnt   <= LatchReload;
                            latch <= 1'b1;
                            state <= StLatch;
                        end else begin
                            ledindex <= ledindex + 8'd1;
                            cnt      <= PixReload;
                            state    <= StSettle;
                        end
                    end
                end
                StLatch: begin
                    if (cnt == '0) begin
                        latch       <= 1'b0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        ledindex    <= '0;
`ifdef SCHED_PENDING_TICK_EN
                        // A tick on the exit cycle counts as pending too.
                        if (pending || frame_tick) begin
                            pending <= 1'b0;
                            cnt     <= PixReload;
                            state   <= StSettle;
                        end else begin
                            busy  <= 1'b0;
                            state <= StIdle;
                        end
`else
                        busy  <= 1'b0;
                        state <= StIdle;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2811_frame_scheduler.sv
// Self-checking bench for ws2811_frame_scheduler: small frame DUT plus a 256-LED DUT.
module tb_ws2811_frame_scheduler;

    localparam int N = 3;
    localparam int P = 8;
    localparam int L = 10;

    logic        clk = 1'b0;
    logic        rst, frame_tick, pix_ready;
    logic [7:0]  ledindex, red, green, blue;
    logic        pix_valid, latch, busy, frame_done;
    logic [23:0] pix_data;
    logic [15:0] frame_count;

    logic        b_tick, b_valid, b_latch, b_busy, b_done;
    logic [7:0]  b_led, b_red, b_green, b_blue;
    logic [23:0] b_data;
    logic [15:0] b_count;

    logic [7:0]  tab_r [256];
    logic [7:0]  tab_g [256];
    logic [7:0]  tab_b [256];

    int          n_checks = 0;
    int          n_pass = 0;
    int          b_hs = 0;
    logic [15:0] exp_count = '0;

    always #5 clk = ~clk;

    assign red     = tab_r[ledindex];
    assign green   = tab_g[ledindex];
    assign blue    = tab_b[ledindex];
    assign b_red   = b_led;
    assign b_green = ~b_led;
    assign b_blue  = b_led ^ 8'h5a;

    ws2811_frame_scheduler #(.NUM_LEDS(N), .PIXEL_CYCLES(P), .LATCH_CYCLES(L)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .ledindex(ledindex),
        .red(red), .green(green), .blue(blue), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .latch(latch), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    ws2811_frame_scheduler #(.NUM_LEDS(256), .PIXEL_CYCLES(1), .LATCH_CYCLES(1)) dut_max (
        .clk(clk), .rst(rst), .frame_tick(b_tick), .ledindex(b_led),
        .red(b_red), .green(b_green), .blue(b_blue), .pix_valid(b_valid),
        .pix_ready(1'b1), .pix_data(b_data), .latch(b_latch), .busy(b_busy),
        .frame_done(b_done), .frame_count(b_count)
    );

    always @(posedge clk) if (b_valid) b_hs <= b_hs + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_ledindex", ledindex, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_latch", latch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
    endtask

    task automatic start_frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ledindex", ledindex, 0);
    endtask

    // Called just after ledindex has taken value idx.
    task automatic run_pixel(input int idx, input int d, input bit rnd);
        logic [23:0] exp;
        exp = {tab_r[idx], tab_g[idx], tab_b[idx]};
        chk("pix_ledindex", ledindex, idx);
        chk("pix_busy", busy, 1);
        for (int i = 1; i < P; i++) begin
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            chk("settle_valid_low", pix_valid, 0);
        end
        pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
        chk("sample_valid", pix_valid, 1);
        chk("sample_data", pix_data, exp);
        chk("sample_latch", latch, 0);
        if (d > 0) begin
            pix_ready = 1'b0;
            for (int i = 0; i < d; i++) begin
                step();
                chk("bp_valid", pix_valid, 1);
                chk("bp_data", pix_data, exp);
                chk("bp_ledindex", ledindex, idx);
            end
        end
        pix_ready = 1'b1;
        step();
        chk("hs_valid_clear", pix_valid, 0);
    endtask

    task automatic run_latch(input int tick_at);
        for (int i = 0; i < L; i++) begin
            chk("latch_high", latch, 1);
            chk("latch_done_low", frame_done, 0);
            chk("latch_busy", busy, 1);
            frame_tick = (tick_at >= 0) && ((i == tick_at) || (i == tick_at + 1));
            step();
        end
        frame_tick = 1'b0;
        exp_count = exp_count + 16'd1;
        chk("exit_latch_low", latch, 0);
        chk("exit_frame_done", frame_done, 1);
        chk("exit_frame_count", frame_count, exp_count);
        chk("exit_ledindex", ledindex, 0);
    endtask

    task automatic frame_body(input int bp_led, input int bp_len, input int tick_at, input bit rnd);
        int d;
        for (int idx = 0; idx < N; idx++) begin
            d = (idx == bp_led) ? bp_len : (rnd ? int'($urandom_range(0, 3)) : 0);
            run_pixel(idx, d, rnd);
        end
        run_latch(tick_at);
    endtask

    task automatic idle_after();
        step();
        chk("post_done_low", frame_done, 0);
        chk("post_busy", busy, 0);
        repeat (4) step();
        chk("idle_busy", busy, 0);
        chk("idle_valid", pix_valid, 0);
        chk("idle_latch", latch, 0);
        chk("idle_count", frame_count, exp_count);
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; pix_ready = 1'b0; b_tick = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tab_r[i] = 8'(i); tab_g[i] = 8'(2 * i); tab_b[i] = 8'(3 * i);
        end
        repeat (2) step();
        chk_reset_vals();
        rst = 1'b0;
        step();
        chk_reset_vals();

        // Abort during SETTLE of LED 1; a tick while busy must not survive the reset.
        start_frame();
        run_pixel(0, 0, 1'b0);
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals();
        idle_after();

        // Basic frame: 000000, 010203, 020406.
        start_frame();
        frame_body(-1, 0, -1, 1'b0);
        idle_after();

        // Backpressure on LED 1 for 20 clocks.
        start_frame();
        frame_body(1, 20, -1, 1'b0);
        idle_after();

        // Two ticks during LATCH.
        start_frame();
        frame_body(-1, 0, 3, 1'b0);
`ifdef SCHED_PENDING_TICK_EN
        chk("chain_busy", busy, 1);
        frame_body(-1, 0, -1, 1'b0);
`endif
        idle_after();

        // Random colours and random handshake timing.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) begin
                tab_r[i] = 8'($urandom); tab_g[i] = 8'($urandom); tab_b[i] = 8'($urandom);
            end
            start_frame();
            frame_body(-1, 0, -1, 1'b1);
            idle_after();
        end

        // Frame counter wrap.
        force dut.frame_count = 16'hffff;
        step();
        release dut.frame_count;
        step();
        exp_count = 16'hffff;
        chk("wrap_preload", frame_count, 16'hffff);
        start_frame();
        frame_body(-1, 0, -1, 1'b0);
        chk("wrap_zero", frame_count, 0);
        idle_after();

        // 256-LED frame with one-cycle settle and latch.
        b_tick = 1'b1;
        step();
        b_tick = 1'b0;
        chk("max_busy", b_busy, 1);
        for (int idx = 0; idx < 256; idx++) begin
            logic [7:0] i8;
            i8 = 8'(idx);
            step();
            chk("max_valid", b_valid, 1);
            chk("max_ledindex", b_led, i8);
            chk("max_data", b_data, {i8, ~i8, i8 ^ 8'h5a});
            chk("max_latch_low", b_latch, 0);
            step();
            chk("max_valid_clear", b_valid, 0);
            if (idx < 255) chk("max_next_index", b_led, idx + 1);
        end
        chk("max_latch", b_latch, 1);
        chk("max_last_index", b_led, 255);
        step();
        chk("max_latch_end", b_latch, 0);
        chk("max_done", b_done, 1);
        chk("max_count", b_count, 1);
        chk("max_handshakes", b_hs, 256);
        step();
        chk("max_idle", b_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
